// File: rtl/pwm_mc_if.sv
// rtl/pwm_mc_if.sv - control and output bundle between a PWM client and pwm_mc
interface pwm_mc_if #(
  parameter int WIDTH = 11,
  parameter int NCH   = 2,
  parameter int DT_W  = 4
);
  logic                 en;
  logic [NCH*WIDTH-1:0] duty;
  logic [DT_W-1:0]      dead;
  logic [NCH-1:0]       PWM_sig;
  logic [NCH-1:0]       PWM_sig_n;
  logic                 prd_start;

  modport master (
    output en, duty, dead,
    input  PWM_sig, PWM_sig_n, prd_start
  );

  modport slave (
    input  en, duty, dead,
    output PWM_sig, PWM_sig_n, prd_start
  );
endinterface

// File: rtl/pwm_mc.sv
// rtl/pwm_mc.sv - multi-channel PWM with shadowed duty and period-start strobe
// Dead-time insertion is built only when PWM_DEADTIME_EN is defined.
module pwm_mc #(
  parameter int WIDTH = 11,
  parameter int NCH   = 2,
  parameter int DT_W  = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  pwm_mc_if.slave bus
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_sh [NCH];
  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   raw_nxt;
  logic             prd_start_q;
  logic             wrap;

  assign wrap = bus.en && (cnt == CNT_MAX);

  always_comb begin
    raw_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      raw_nxt[i] = bus.en && (cnt < duty_sh[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      prd_start_q <= 1'b0;
      raw         <= '0;
    end else begin
      cnt         <= bus.en ? cnt + 1'b1 : '0;
      prd_start_q <= wrap;
      raw         <= raw_nxt;
    end
  end

  // Shadow follows the input freely while disabled so the first period after enable uses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        duty_sh[i] <= '0;
      end
    end else if (!bus.en || wrap) begin
      for (int i = 0; i < NCH; i++) begin
        duty_sh[i] <= bus.duty[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.prd_start = prd_start_q;

`ifdef PWM_DEADTIME_EN
  logic [DT_W-1:0] dt [NCH];

  // Any raw edge (re)starts the blanking window, including one inside a running window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        dt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (raw_nxt[i] != raw[i]) begin
          dt[i] <= bus.dead;
        end else if (dt[i] != '0) begin
          dt[i] <= dt[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.PWM_sig   = '0;
    bus.PWM_sig_n = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.PWM_sig[i]   = raw[i] && (dt[i] == '0);
      bus.PWM_sig_n[i] = !raw[i] && (dt[i] == '0);
    end
  end
`else
  assign bus.PWM_sig   = raw;
  assign bus.PWM_sig_n = ~raw;
`endif
endmodule

// File: tb/tb_pwm_mc.sv
// tb/tb_pwm_mc.sv - self-checking bench for pwm_mc (WIDTH=4, NCH=2)
module tb_pwm_mc;
  localparam int WIDTH  = 4;
  localparam int NCH    = 2;
  localparam int DT_W   = 4;
  localparam int PERIOD = 16;
  localparam int AGE_MAX = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  pwm_mc_if #(.WIDTH(WIDTH), .NCH(NCH), .DT_W(DT_W)) bus ();

  pwm_mc #(.WIDTH(WIDTH), .NCH(NCH), .DT_W(DT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: period position, latched duty per period, and cycles since the last compare flip.
  int m_cnt;
  int m_dsh [NCH];
  bit m_raw [NCH];
  bit m_prd;
  int m_age [NCH];

  typedef struct {
    int d0;
    int d1;
    int dead;
    int hi0;
    int hi1;
    int dt_hi0;
    int dt_hi1;
  } vec_t;

  vec_t vecs [6];

  function automatic int dead_eff();
`ifdef PWM_DEADTIME_EN
    return int'(bus.dead);
`else
    return 0;
`endif
  endfunction

  function automatic int duty_of(int i);
    return int'(bus.duty[i*WIDTH +: WIDTH]);
  endfunction

  function automatic void model_reset();
    m_cnt = 0;
    m_prd = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_dsh[i] = 0;
      m_raw[i] = 1'b0;
      m_age[i] = AGE_MAX;
    end
  endfunction

  function automatic void model_clock();
    bit nr;
    bit last;
    if (!rst_n) begin
      model_reset();
      return;
    end
    last  = bus.en && (m_cnt == PERIOD - 1);
    m_prd = last;
    for (int i = 0; i < NCH; i++) begin
      nr = bus.en && (m_cnt < m_dsh[i]);
      if (nr != m_raw[i]) m_age[i] = 0;
      else if (m_age[i] < AGE_MAX) m_age[i] = m_age[i] + 1;
      m_raw[i] = nr;
      if (!bus.en || last) m_dsh[i] = duty_of(i);
    end
    m_cnt = bus.en ? (m_cnt + 1) % PERIOD : 0;
  endfunction

  task automatic check1(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] es;
    logic [NCH-1:0] en_n;
    for (int i = 0; i < NCH; i++) begin
      es[i]   = m_raw[i] && (m_age[i] >= dead_eff());
      en_n[i] = !m_raw[i] && (m_age[i] >= dead_eff());
    end
    check1("pwm_sig", int'(bus.PWM_sig), int'(es));
    check1("pwm_sig_n", int'(bus.PWM_sig_n), int'(en_n));
    check1("prd_start", int'(bus.prd_start), int'(m_prd));
    check1("no_overlap", int'(|(bus.PWM_sig & bus.PWM_sig_n)), 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_duty(input int d0, input int d1);
    bus.duty[0 +: WIDTH]     = d0[WIDTH-1:0];
    bus.duty[WIDTH +: WIDTH] = d1[WIDTH-1:0];
  endtask

  function automatic int lo_exp(int d, int dd);
    if (d == 0) return PERIOD;
    return (PERIOD - d - dd > 0) ? PERIOD - d - dd : 0;
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish before 500000");
    $fatal(1);
  end

  initial begin
    int h0, h1, l0, l1, p, k, rises;
    bit prev;

    vecs[0] = '{d0: 5,  d1: 12, dead: 0, hi0: 5,  hi1: 12, dt_hi0: 5,  dt_hi1: 12};
    vecs[1] = '{d0: 0,  d1: 15, dead: 0, hi0: 0,  hi1: 15, dt_hi0: 0,  dt_hi1: 15};
    vecs[2] = '{d0: 15, d1: 0,  dead: 3, hi0: 15, hi1: 0,  dt_hi0: 12, dt_hi1: 0};
    vecs[3] = '{d0: 6,  d1: 6,  dead: 2, hi0: 6,  hi1: 6,  dt_hi0: 4,  dt_hi1: 4};
    vecs[4] = '{d0: 6,  d1: 1,  dead: 7, hi0: 6,  hi1: 1,  dt_hi0: 0,  dt_hi1: 0};
    vecs[5] = '{d0: 1,  d1: 8,  dead: 1, hi0: 1,  hi1: 8,  dt_hi0: 0,  dt_hi1: 7};

    bus.en   = 1'b1;
    bus.dead = '0;
    set_duty(5, 12);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check1("reset_sig", int'(bus.PWM_sig), 0);
    check1("reset_sig_n", int'(bus.PWM_sig_n), 3);
    check1("reset_prd", int'(bus.prd_start), 0);

    @(negedge clk);
    rst_n = 1'b1;
    h0 = 0; l0 = 0;
    repeat (PERIOD) begin
      step();
      h0 += int'(bus.PWM_sig != '0);
      l0 += int'(bus.PWM_sig_n == 2'b11);
    end
    check1("first_period_sig_off", h0, 0);
    check1("first_period_sig_n_on", l0, PERIOD);
    h0 = 0; h1 = 0; p = 0;
    repeat (PERIOD) begin
      step();
      h0 += int'(bus.PWM_sig[0]);
      h1 += int'(bus.PWM_sig[1]);
      p  += int'(bus.prd_start);
    end
    check1("steady_hi0", h0, 5);
    check1("steady_hi1", h1, 12);
    check1("steady_prd", p, 1);

    for (int v = 0; v < 6; v++) begin
      bus.en = 1'b0;
      run(10);
      bus.dead = vecs[v].dead[DT_W-1:0];
      set_duty(vecs[v].d0, vecs[v].d1);
      bus.en = 1'b1;
      run(32);
      h0 = 0; h1 = 0; l0 = 0; l1 = 0; p = 0;
      repeat (PERIOD) begin
        step();
        h0 += int'(bus.PWM_sig[0]);
        h1 += int'(bus.PWM_sig[1]);
        l0 += int'(bus.PWM_sig_n[0]);
        l1 += int'(bus.PWM_sig_n[1]);
        p  += int'(bus.prd_start);
      end
`ifdef PWM_DEADTIME_EN
      check1($sformatf("vec%0d_hi0", v), h0, vecs[v].dt_hi0);
      check1($sformatf("vec%0d_hi1", v), h1, vecs[v].dt_hi1);
      check1($sformatf("vec%0d_lo0", v), l0, lo_exp(vecs[v].d0, vecs[v].dead));
      check1($sformatf("vec%0d_lo1", v), l1, lo_exp(vecs[v].d1, vecs[v].dead));
`else
      check1($sformatf("vec%0d_hi0", v), h0, vecs[v].hi0);
      check1($sformatf("vec%0d_hi1", v), h1, vecs[v].hi1);
      check1($sformatf("vec%0d_lo0", v), l0, lo_exp(vecs[v].d0, 0));
      check1($sformatf("vec%0d_lo1", v), l1, lo_exp(vecs[v].d1, 0));
`endif
      check1($sformatf("vec%0d_prd", v), p, 1);
    end

    // Shadow update mid-period: 4 -> 10 at cnt=2.
    bus.en = 1'b0;
    run(10);
    bus.dead = '0;
    set_duty(4, 4);
    bus.en = 1'b1;
    run(20);
    k = 0;
    while (!bus.prd_start && k < 40) begin
      step();
      k++;
    end
    check1("shadow_sync", int'(bus.prd_start), 1);
    h0 = int'(bus.PWM_sig[0]);
    prev = bus.PWM_sig[0];
    rises = 0;
    for (int i = 1; i < PERIOD; i++) begin
      step();
      h0 += int'(bus.PWM_sig[0]);
      if (bus.PWM_sig[0] && !prev) rises++;
      prev = bus.PWM_sig[0];
      if (i == 2) set_duty(10, 4);
    end
    check1("shadow_cur_period", h0, 4);
    h0 = 0;
    repeat (PERIOD) begin
      step();
      h0 += int'(bus.PWM_sig[0]);
      if (bus.PWM_sig[0] && !prev) rises++;
      prev = bus.PWM_sig[0];
    end
    check1("shadow_next_period", h0, 10);
    check1("shadow_pulse_count", rises, 2);

    // Enable toggle at cnt=7.
    set_duty(10, 10);
    run(40);
    k = 0;
    while (m_cnt != 7 && k < 40) begin
      step();
      k++;
    end
    check1("en_sync_cnt7", m_cnt, 7);
    check1("en_before_drop", int'(bus.PWM_sig[0]), 1);
    bus.en = 1'b0;
    repeat (5) begin
      step();
      check1("dis_sig_off", int'(bus.PWM_sig), 0);
      check1("dis_prd_off", int'(bus.prd_start), 0);
    end
    bus.en = 1'b1;
    p = 0;
    repeat (PERIOD - 1) begin
      step();
      p += int'(bus.prd_start);
    end
    check1("reen_no_early_prd", p, 0);
    step();
    check1("reen_first_prd", int'(bus.prd_start), 1);

    // Randomized segments; dead only changes after outputs have settled with en low.
    for (int s = 0; s < 4; s++) begin
      bus.en = 1'b0;
      run(12);
      bus.dead = DT_W'($urandom_range(0, 7));
      set_duty(int'($urandom_range(0, PERIOD - 1)), int'($urandom_range(0, PERIOD - 1)));
      bus.en = 1'b1;
      repeat (150) begin
        if ($urandom % 8 == 0)
          set_duty(int'($urandom_range(0, PERIOD - 1)), int'($urandom_range(0, PERIOD - 1)));
        if ($urandom % 50 == 0) bus.en = ~bus.en;
        step();
      end
    end

    // Asynchronous reset with PWM_sig high.
    bus.en = 1'b0;
    run(12);
    bus.dead = '0;
    set_duty(10, 10);
    bus.en = 1'b1;
    run(20);
    k = 0;
    while (!bus.PWM_sig[0] && k < 40) begin
      step();
      k++;
    end
    check1("arst_sig_high_before", int'(bus.PWM_sig[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check1("arst_sig", int'(bus.PWM_sig), 0);
    check1("arst_sig_n", int'(bus.PWM_sig_n), 3);
    check1("arst_prd", int'(bus.prd_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    h0 = 0;
    repeat (PERIOD) begin
      step();
      h0 += int'(bus.PWM_sig != '0);
    end
    check1("arst_duty_sh_cleared", h0, 0);
    h0 = 0;
    repeat (PERIOD) begin
      step();
      h0 += int'(bus.PWM_sig[0]);
    end
    check1("arst_resume_hi0", h0, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_mc.md
# pwm_mc

Multi-channel, parametrised PWM generator for the motor-drive path; the next generation of the team's fixed 11-bit single-channel PWM. All channels share one free-running counter. Each channel takes its duty through a shadow register that updates only at period boundaries, which gives glitch-free duty changes. Channels drive complementary outputs with optional dead-time insertion, and the block emits a period-start strobe for ADC or control-loop synchronisation.

## Interface
Parameters:
- WIDTH, 11, counter and duty width; period = 2^WIDTH clocks
- NCH, 2, number of PWM channels
- DT_W, 4, dead-time count width

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  counter enable; 0 holds counter at 0 and forces all channels off
- duty  input  NCH*WIDTH  channel i duty at bits [i*WIDTH +: WIDTH], unsigned
- dead  input  DT_W  dead-time in clocks, common to all channels; quasi-static
- PWM_sig  output  NCH  high-side PWM per channel
- PWM_sig_n  output  NCH  complementary low-side PWM per channel
- prd_start  output  1  one-clock strobe in the first cycle of each period

## Operation
- Counter `cnt` (WIDTH bits) increments every clock while en=1 and wraps from 2^WIDTH-1 to 0. While en=0 it is held at 0.
- Shadow: duty_sh[i] loads duty[i] in any cycle where cnt == 2^WIDTH-1 with en=1, and in every cycle where en=0. Duty changes at other times take effect in the next period.
- Raw compare per channel: raw[i] (registered) <= en & (cnt < duty_sh[i]).
  - duty_sh=0: raw is never high.
  - duty_sh=2^WIDTH-1: raw is low for exactly 1 clock per period.
  - 100% duty is not representable.
- Output without dead-time:
  - PWM_sig = raw.
  - PWM_sig_n = ~raw.
- Output with dead-time: see Configuration.
- prd_start (registered) <= en & (cnt == 2^WIDTH-1). It is high in the cycle when cnt == 0.
- Reset values:
  - cnt=0, duty_sh=0, raw=0, prd_start=0.
  - PWM_sig=0, PWM_sig_n=1 in both configurations.
  - Dead-time counters are reset to 0.
- Reset asserted mid-period forces the reset values immediately (asynchronous). The first period after release starts at cnt=0 with duty_sh=0, so output stays off until the first boundary load.

## Timing
- Compare latency: cnt value k determines raw in the next cycle. PWM_sig rises 1 clock after cnt=0 and stays high for duty_sh clocks.
- Duty update latency is at most one period plus 1 clock. The new duty is first visible on PWM_sig 1 clock after prd_start.
- Disable: en 1->0 drives raw low on the next edge, and cnt reads 0 on the same edge.
- Enable: en 0->1 leaves cnt at 0 in that cycle; it increments from the next edge. No prd_start is issued for this first period; the first strobe follows the first wrap.

## Configuration
PWM_DEADTIME_EN.

- Defined: each channel holds a dead-time counter dt[i] (DT_W bits). Every raw[i] edge loads dt[i] with `dead`. While dt[i] != 0:
  - both PWM_sig[i] and PWM_sig_n[i] are 0;
  - dt[i] decrements each clock.
- Once dt[i]==0: PWM_sig=raw and PWM_sig_n=~raw.
  - The output turning off does so in the same cycle as the raw edge.
  - The output turning on is delayed by `dead` clocks.
- A raw edge during dead-time reloads dt[i] with `dead`.
- If duty_sh <= dead, PWM_sig never asserts.
- dead=0 gives behaviour identical to the undefined case.
- Outputs are never high simultaneously.
- Undefined: no dt counters exist, and `dead` is ignored.

## Test plan
- Reset and steady operation. Setup: WIDTH=4, NCH=2, duty={5,12}, en=1, reset released.
  - The first period is fully off, with PWM_sig_n=2'b11.
  - From the second period, PWM_sig[0] is high 5 of 16 clocks and PWM_sig[1] is high 12 of 16.
  - prd_start fires every 16 clocks.
- Duty extremes: duty=0, then duty=15.
  - duty=0: PWM_sig stays 0 and PWM_sig_n stays 1 for a whole period.
  - duty=15: PWM_sig is low exactly 1 clock per period.
- Shadow update: change duty 4->10 at cnt=2.
  - The current period still gives 4 high clocks; the next period gives 10.
  - There are no runt pulses.
- Enable toggle: drop en at cnt=7, hold it low for 5 clocks, then raise it.
  - PWM_sig goes 0 on the next edge and cnt holds 0.
  - After re-enable the counter restarts from 0, and prd_start resumes after the first wrap.
- Dead-time (PWM_DEADTIME_EN defined): dead=2, duty=6.
  - PWM_sig is high 4 clocks per period.
  - Both outputs are low for 2 clocks after each edge, and they are never both high.
  - With dead=7 and duty=6, PWM_sig never rises.
- Asynchronous reset: assert rst_n=0 mid-period with PWM_sig high.
  - Outputs go to PWM_sig=0, PWM_sig_n=1 without waiting for a clock edge.
  - prd_start=0 and duty_sh is cleared.
